// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, long-latency results queued in a FIFO.
// rf_* is combinational (0-cycle); ll_ready = ~full from the registered count; hold_req forces a drain.
// Optional WB_ARB_PERF_EN adds perf_defer_cnt, counting cycles a queued result lost to the pipeline.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        ll_valid,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        hold_req
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0] perf_defer_cnt
`endif
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int SW   = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    state_t          state_q, state_d;

    logic empty, full, ll_fire, ll_wr, pipe_fire, pop, bypass, push;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNTW'(DEPTH));
        ll_ready  = ~reset & ~full;
        ll_fire   = ll_valid & ll_ready;
        ll_wr     = ll_fire & (ll_rd != 5'd0);
        pipe_fire = ~reset & pipe_we & ~stall & ~flush & (pipe_rd != 5'd0);
        pop       = ~reset & ~empty & ~pipe_fire;
        bypass    = ~reset & empty & ~pipe_fire & ll_wr;
        push      = ll_wr & ~bypass;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = 32'd0;
        if (pipe_fire) begin
            rf_we    = 1'b1;
            rf_rd    = pipe_rd;
            rf_wdata = pipe_data;
        end else if (pop) begin
            rf_we    = 1'b1;
            rf_rd    = rd_mem_q[rd_ptr_q];
            rf_wdata = data_mem_q[rd_ptr_q];
        end else if (bypass) begin
            rf_we    = 1'b1;
            rf_rd    = ll_rd;
            rf_wdata = ll_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // Starvation only accrues while a queued result is denied the port in favour of the pipeline.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            S_IDLE: begin
                if (empty || pop) begin
                    starve_d = '0;
                end else if (pipe_fire) begin
                    if (starve_q == SW'(STARVE_MAX - 1)) begin
                        state_d  = S_HOLD;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_HOLD: begin
                starve_d = '0;
                if (pop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                starve_d = '0;
            end
        endcase
    end

    assign hold_req = (state_q == S_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            state_q  <= S_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            state_q  <= state_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= ll_rd;
            data_mem_q[wr_ptr_q] <= ll_data;
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q + {31'd0, (~empty & pipe_fire)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_defer_cnt = perf_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomised + directed bench for wb_port_arbiter: a queue-based reference model predicts each
// register-file write; a negedge monitor pops and compares whatever the DUT writes.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        ll_valid = 1'b0;
    logic [4:0]  ll_rd = 5'd0;
    logic [31:0] ll_data = 32'd0;
    logic        ll_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        hold_req;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_defer_cnt;
`endif

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .ll_valid  (ll_valid),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .ll_ready  (ll_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .hold_req  (hold_req)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_defer_cnt (perf_defer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         fifo_m[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int          m_starve = 0;
    bit          m_hold = 1'b0;
    bit          m_reset = 1'b1;
    int unsigned m_perf = 0;

    // One clock: check registered outputs, drive inputs, advance the reference model.
    task automatic cyc(input bit r, input bit st, input bit fl, input bit pwe,
                       input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit  pf, llf, popped, byp, nonempty;
        wr_t w;
        @(posedge clk);
        #1;
        checks++;
        if (ll_ready !== (!m_reset && fifo_m.size() < DEPTH)) begin
            errors++;
            $display("FAIL ll_ready: got %b exp %b (model fill %0d)", ll_ready,
                     (!m_reset && fifo_m.size() < DEPTH), fifo_m.size());
        end
        checks++;
        if (hold_req !== m_hold) begin
            errors++;
            $display("FAIL hold_req: got %b exp %b", hold_req, m_hold);
        end
`ifdef WB_ARB_PERF_EN
        checks++;
        if (perf_defer_cnt !== m_perf) begin
            errors++;
            $display("FAIL perf_defer_cnt: got %0d exp %0d", perf_defer_cnt, m_perf);
        end
`endif
        reset = r; stall = st; flush = fl; pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        ll_valid = lv; ll_rd = lrd; ll_data = ld;
        mon_en = 1'b1;
        if (r) begin
            fifo_m.delete();
            m_starve = 0;
            m_hold = 1'b0;
            m_perf = 0;
        end else begin
            llf = lv && (fifo_m.size() < DEPTH);
            pf = pwe && !st && !fl && (prd != 5'd0);
            nonempty = (fifo_m.size() > 0);
            popped = 1'b0;
            byp = 1'b0;
            if (pf) begin
                w.rd = prd; w.data = pd;
                exp_q.push_back(w);
                if (nonempty) m_perf++;
            end else if (nonempty) begin
                w = fifo_m.pop_front();
                exp_q.push_back(w);
                popped = 1'b1;
            end else if (llf && lrd != 5'd0) begin
                w.rd = lrd; w.data = ld;
                exp_q.push_back(w);
                byp = 1'b1;
            end
            if (llf && lrd != 5'd0 && !byp) begin
                w.rd = lrd; w.data = ld;
                fifo_m.push_back(w);
            end
            if (!m_hold) begin
                if (nonempty && !popped) begin
                    m_starve++;
                    if (m_starve == SMAX) begin
                        m_hold = 1'b1;
                        m_starve = 0;
                    end
                end else begin
                    m_starve = 0;
                end
            end else if (popped) begin
                m_hold = 1'b0;
            end
        end
        m_reset = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Pipeline writes every cycle while two ll results queue up; ends with the arbiter in HOLD.
    task automatic fill_to_hold();
        cyc(0, 0, 0, 1, 5'd9, 32'h9000_0000, 1, 5'd1, 32'h1111_1111);
        cyc(0, 0, 0, 1, 5'd9, 32'h9000_0001, 1, 5'd2, 32'h2222_2222);
        cyc(0, 0, 0, 1, 5'd9, 32'h9000_0002, 1, 5'd3, 32'h3333_3333);
        cyc(0, 0, 0, 1, 5'd9, 32'h9000_0003, 0, 5'd0, 32'd0);
        cyc(0, 0, 0, 1, 5'd9, 32'h9000_0004, 0, 5'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (mon_en) begin
            checks++;
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rf_write: unexpected write rd=%0d data=%h, none required", rf_rd, rf_wdata);
                end else begin
                    w = exp_q.pop_front();
                    if (rf_rd !== w.rd || rf_wdata !== w.data) begin
                        errors++;
                        $display("FAIL rf_write: got rd=%0d data=%h exp rd=%0d data=%h",
                                 rf_rd, rf_wdata, w.rd, w.data);
                    end
                end
            end else if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
                errors++;
                $display("FAIL rf_idle: got we=%b rd=%0d data=%h exp all zero", rf_we, rf_rd, rf_wdata);
            end else if (exp_q.size() != 0) begin
                errors++;
                w = exp_q.pop_front();
                $display("FAIL rf_write: got no write exp rd=%0d data=%h", w.rd, w.data);
            end
        end
    end

    initial begin
        bit st, r;
        cyc(1, 0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        cyc(1, 0, 0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h5);
        idle(2);
        // single pipe write, then the same with stall and with flush
        cyc(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        cyc(0, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        cyc(0, 0, 1, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0);
        // bypass from an empty FIFO
        cyc(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h1234);
        idle(1);
        // rd==0 on either path never writes
        cyc(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hAAAA);
        cyc(0, 0, 0, 1, 5'd0, 32'hBBBB, 0, 5'd0, 32'd0);
        idle(1);
        // starvation into HOLD, then drain under stall
        fill_to_hold();
        cyc(0, 1, 0, 1, 5'd9, 32'h9000_0005, 0, 5'd0, 32'd0);
        cyc(0, 1, 0, 1, 5'd9, 32'h9000_0006, 0, 5'd0, 32'd0);
        idle(2);
        // full FIFO: pop and ll_valid together, ll refused, ready again a cycle later
        cyc(0, 0, 0, 1, 5'd4, 32'h4000_0000, 1, 5'd11, 32'hB0B0_0001);
        cyc(0, 0, 0, 1, 5'd4, 32'h4000_0001, 1, 5'd12, 32'hB0B0_0002);
        cyc(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd13, 32'hB0B0_0003);
        cyc(0, 0, 0, 0, 5'd0, 32'd0, 1, 5'd14, 32'hB0B0_0004);
        idle(3);
        // reset while full and holding
        fill_to_hold();
        cyc(1, 0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = m_hold ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            cyc(r, st, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 31)), $urandom);
        end
        cyc(1, 0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(1);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d required writes never seen, exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
